// File: rtl/vx_lru_repl.sv
// Per-set true-LRU replacement tracker with TOUCH/FILL/INVAL and a one-set-per-cycle FLUSH sweep.
// Each set keeps an explicit order list (position 0 = LRU) plus a valid bit per way.
module vx_lru_repl #(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned SET_SEL  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int unsigned WAY_SEL  = $clog2(NUM_WAYS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [SET_SEL-1:0] req_set,
  input  logic [WAY_SEL-1:0] req_way,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WAY_SEL-1:0] rsp_way,
  output logic               rsp_evict,
  output logic               busy
);

  typedef logic [WAY_SEL-1:0] way_t;
  typedef enum logic [1:0] {OP_TOUCH = 2'b00, OP_FILL = 2'b01, OP_INVAL = 2'b10, OP_FLUSH = 2'b11} op_e;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  state_e               state;
  logic [SET_SEL-1:0]   flush_idx;
  way_t                 order_q [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];

  op_e                  op;
  logic                 req_fire;
  way_t                 cur_order [NUM_WAYS];
  logic [NUM_WAYS-1:0]  cur_valid;
  way_t                 victim;
  logic                 found_inv;
  way_t                 move_way;
  int unsigned          move_pos;
  way_t                 mru_order [NUM_WAYS];
  way_t                 lru_order [NUM_WAYS];

  assign op        = op_e'(req_op);
  assign req_ready = reset_n && (state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    cur_order = order_q[req_set];
    cur_valid = valid_q[req_set];

    victim    = cur_order[0];
    found_inv = 1'b0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (!found_inv && !cur_valid[i]) begin
        victim    = way_t'(i);
        found_inv = 1'b1;
      end
    end

    move_way = (op == OP_FILL) ? victim : req_way;
    move_pos = 0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (cur_order[i] == move_way) move_pos = i;
    end

    // MRU promotion closes the gap from above; LRU demotion opens a slot at position 0.
    for (int unsigned i = 0; i < NUM_WAYS - 1; i++) begin
      mru_order[i] = (i < move_pos) ? cur_order[i] : cur_order[i+1];
    end
    mru_order[NUM_WAYS-1] = move_way;

    lru_order[0] = move_way;
    for (int unsigned i = 1; i < NUM_WAYS; i++) begin
      lru_order[i] = (i <= move_pos) ? cur_order[i-1] : cur_order[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      flush_idx <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_way   <= '0;
      rsp_evict <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          order_q[s][w] <= way_t'(w);
        end
        valid_q[s] <= '0;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
          if (req_fire) begin
            unique case (op)
              OP_TOUCH: begin
                if (cur_valid[req_way]) order_q[req_set] <= mru_order;
                rsp_valid <= 1'b1;
                rsp_way   <= req_way;
                rsp_evict <= 1'b0;
              end
              OP_FILL: begin
                order_q[req_set]         <= mru_order;
                valid_q[req_set][victim] <= 1'b1;
                rsp_valid                <= 1'b1;
                rsp_way                  <= victim;
                rsp_evict                <= cur_valid[victim];
              end
              OP_INVAL: begin
                order_q[req_set]          <= lru_order;
                valid_q[req_set][req_way] <= 1'b0;
                rsp_valid                 <= 1'b1;
                rsp_way                   <= req_way;
                rsp_evict                 <= 1'b0;
              end
              OP_FLUSH: begin
                state     <= ST_FLUSH;
                busy      <= 1'b1;
                flush_idx <= '0;
              end
            endcase
          end
        end
        ST_FLUSH: begin
          for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            order_q[flush_idx][w] <= way_t'(w);
          end
          valid_q[flush_idx] <= '0;
          if (flush_idx == SET_SEL'(NUM_SETS - 1)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_way   <= '0;
            rsp_evict <= 1'b0;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vx_lru_repl.sv
// Directed bench for vx_lru_repl with NUM_SETS=4, NUM_WAYS=4; expected ways are hand-derived LRU sequences.
module tb_vx_lru_repl;

  localparam logic [1:0] TOUCH = 2'b00, FILL = 2'b01, INVAL = 2'b10, FLUSH = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_set;
  logic [1:0] req_way;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_way;
  logic       rsp_evict;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  vx_lru_repl #(.NUM_SETS(4), .NUM_WAYS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_set(req_set), .req_way(req_way),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_way(rsp_way),
    .rsp_evict(rsp_evict), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_set = '0; req_way = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives one request until accepted (bounded) and samples the response just after the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [1:0] set, input logic [1:0] way,
                        output logic o_valid, output logic [1:0] o_way, output logic o_evict);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_set = set; req_way = way;
    for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    o_valid = rsp_valid; o_way = rsp_way; o_evict = rsp_evict;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b1; req_op = FILL; req_set = 2'd0; req_way = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b exp 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if ({rsp_way, rsp_evict} !== 3'b000) begin n_err++; $display("FAIL reset_rsp got %0d/%0b exp 0/0", rsp_way, rsp_evict); end
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %0b exp 1", req_ready); end
  endtask

  task automatic test_fill_order();
    logic v; logic [1:0] w; logic e;
    logic [1:0] exp_w [5];
    logic       exp_e [5];
    exp_w = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_req(FILL, 2'd2, 2'd0, v, w, e);
      n_cmp++;
      if ({v, w, e} !== {1'b1, exp_w[i], exp_e[i]})
        begin n_err++; $display("FAIL fill_set2_%0d got v%0b w%0d e%0b exp v1 w%0d e%0b", i, v, w, e, exp_w[i], exp_e[i]); end
    end
    do_req(FILL, 2'd1, 2'd0, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd0, 1'b0}) begin n_err++; $display("FAIL fill_set1_isolated got v%0b w%0d e%0b exp v1 w0 e0", v, w, e); end
  endtask

  task automatic test_touch();
    logic v; logic [1:0] w; logic e;
    apply_reset();
    do_req(TOUCH, 2'd1, 2'd2, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd2, 1'b0}) begin n_err++; $display("FAIL touch_invalid_rsp got v%0b w%0d e%0b exp v1 w2 e0", v, w, e); end
    do_req(FILL, 2'd1, 2'd0, v, w, e);
    n_cmp++; if ({w, e} !== {2'd0, 1'b0}) begin n_err++; $display("FAIL touch_invalid_nochange got w%0d e%0b exp w0 e0", w, e); end
    for (int i = 0; i < 4; i++) do_req(FILL, 2'd0, 2'd0, v, w, e);
    do_req(TOUCH, 2'd0, 2'd0, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd0, 1'b0}) begin n_err++; $display("FAIL touch_rsp got v%0b w%0d e%0b exp v1 w0 e0", v, w, e); end
    do_req(FILL, 2'd0, 2'd0, v, w, e);
    n_cmp++; if ({w, e} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL touch_fill1 got w%0d e%0b exp w1 e1", w, e); end
    do_req(FILL, 2'd0, 2'd0, v, w, e);
    n_cmp++; if ({w, e} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL touch_fill2 got w%0d e%0b exp w2 e1", w, e); end
  endtask

  task automatic test_inval();
    logic v; logic [1:0] w; logic e;
    apply_reset();
    for (int i = 0; i < 4; i++) do_req(FILL, 2'd3, 2'd0, v, w, e);
    do_req(INVAL, 2'd3, 2'd2, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd2, 1'b0}) begin n_err++; $display("FAIL inval_rsp got v%0b w%0d e%0b exp v1 w2 e0", v, w, e); end
    do_req(FILL, 2'd3, 2'd0, v, w, e);
    n_cmp++; if ({w, e} !== {2'd2, 1'b0}) begin n_err++; $display("FAIL inval_refill got w%0d e%0b exp w2 e0", w, e); end
    do_req(FILL, 2'd3, 2'd0, v, w, e);
    n_cmp++; if ({w, e} !== {2'd0, 1'b1}) begin n_err++; $display("FAIL inval_lru got w%0d e%0b exp w0 e1", w, e); end
  endtask

  task automatic test_backpressure();
    logic v; logic [1:0] w; logic e;
    apply_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    do_req(FILL, 2'd0, 2'd0, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd0, 1'b0}) begin n_err++; $display("FAIL bp_first got v%0b w%0d e%0b exp v1 w0 e0", v, w, e); end
    req_valid = 1'b1; req_op = FILL; req_set = 2'd0; req_way = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_way, rsp_evict, req_ready} !== {1'b1, 2'd0, 1'b0, 1'b0})
        begin n_err++; $display("FAIL bp_hold_%0d got v%0b w%0d e%0b rdy%0b exp v1 w0 e0 rdy0", i, rsp_valid, rsp_way, rsp_evict, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %0b exp 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_way, rsp_evict} !== {1'b1, 2'd1, 1'b0}) begin n_err++; $display("FAIL bp_b2b got v%0b w%0d e%0b exp v1 w1 e0", rsp_valid, rsp_way, rsp_evict); end
    do_req(FILL, 2'd0, 2'd0, v, w, e);
    n_cmp++; if ({w, e} !== {2'd2, 1'b0}) begin n_err++; $display("FAIL bp_after got w%0d e%0b exp w2 e0", w, e); end
  endtask

  task automatic test_flush();
    logic v; logic [1:0] w; logic e;
    int busy_cnt, rsp_cnt, rdy_busy, bad_rsp;
    apply_reset();
    for (int s = 0; s < 4; s++) do_req(FILL, 2'(s), 2'd0, v, w, e);
    @(negedge clk);
    req_valid = 1'b1; req_op = FLUSH; req_set = 2'd1; req_way = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    busy_cnt = 0; rsp_cnt = 0; rdy_busy = 0; bad_rsp = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_cnt++;
      if (busy && req_ready) rdy_busy++;
      if (rsp_valid) begin
        rsp_cnt++;
        if (busy || rsp_way != 2'd0 || rsp_evict) bad_rsp++;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (busy_cnt !== 4) begin n_err++; $display("FAIL flush_busy_cycles got %0d exp 4", busy_cnt); end
    n_cmp++; if (rdy_busy !== 0) begin n_err++; $display("FAIL flush_ready_while_busy got %0d exp 0", rdy_busy); end
    n_cmp++; if (rsp_cnt !== 1) begin n_err++; $display("FAIL flush_rsp_count got %0d exp 1", rsp_cnt); end
    n_cmp++; if (bad_rsp !== 0) begin n_err++; $display("FAIL flush_rsp_fields got %0d bad exp 0", bad_rsp); end
    do_req(FILL, 2'd2, 2'd0, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd0, 1'b0}) begin n_err++; $display("FAIL flush_refill got v%0b w%0d e%0b exp v1 w0 e0", v, w, e); end
  endtask

  task automatic test_flush_abort();
    logic v; logic [1:0] w; logic e;
    int rsp_cnt, busy_cnt;
    apply_reset();
    do_req(FILL, 2'd3, 2'd0, v, w, e);
    @(negedge clk);
    req_valid = 1'b1; req_op = FLUSH; req_set = '0; req_way = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready_in_reset got %0b exp 0", req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    rsp_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_cnt++;
      if (busy) busy_cnt++;
    end
    n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL abort_busy got %0d exp 0", busy_cnt); end
    n_cmp++; if (rsp_cnt !== 0) begin n_err++; $display("FAIL abort_rsp got %0d exp 0", rsp_cnt); end
    do_req(FILL, 2'd3, 2'd0, v, w, e);
    n_cmp++; if ({v, w, e} !== {1'b1, 2'd0, 1'b0}) begin n_err++; $display("FAIL abort_refill got v%0b w%0d e%0b exp v1 w0 e0", v, w, e); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_set = '0; req_way = '0;
    test_reset();
    test_fill_order();
    test_touch();
    test_inval();
    test_backpressure();
    test_flush();
    test_flush_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
